// File: rtl/si5340_i2c_target.sv
// si5340_i2c_target: I2C target bridging a paged 8-bit register space (page register at offset 0x01).
// Ports: clk_i/arstn_i clock and async active-low reset; scl_i/sda_i bus levels;
// sda_o/sda_oen open-drain SDA drive (0 = pull low); reg_addr_o/reg_wdata_o/reg_we_o/reg_re_o
// register strobe interface with reg_rdata_i valid one clk after reg_re_o; busy_o transaction flag.
module si5340_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h74,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oen,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [7:0]  reg_rdata_i,
    output logic        busy_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, OFFS, OFFS_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start, stop;
    logic [7:0]             sr, page, offset;
    logic [3:0]             cnt;
    logic                   nack, ld;

    assign sda_o    = 1'b0;
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state       <= IDLE;
            sr          <= 8'h00;
            cnt         <= 4'd0;
            nack        <= 1'b0;
            ld          <= 1'b0;
            page        <= 8'h00;
            offset      <= 8'h00;
            sda_oen     <= 1'b1;
            busy_o      <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            reg_addr_o  <= 16'h0000;
            reg_wdata_o <= 8'h00;
        end else begin
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;
            ld       <= 1'b0;
            if (start) begin
                // repeated START keeps page/offset so a write-offset/read sequence works
                state   <= ADDR;
                cnt     <= 4'd0;
                sda_oen <= 1'b1;
            end else if (stop) begin
                state   <= IDLE;
                sda_oen <= 1'b1;
                busy_o  <= 1'b0;
            end else if (ld) begin
                // read data arrives one clk after the strobe; drive its MSB straight away
                sr      <= reg_rdata_i;
                sda_oen <= reg_rdata_i[7];
                cnt     <= 4'd0;
            end else begin
                if (scl_rise) begin
                    if (state == ADDR || state == OFFS || state == WDATA) begin
                        sr  <= {sr[6:0], sda_s};
                        cnt <= cnt + 4'd1;
                    end
                    if (state == RDATA) cnt <= cnt + 4'd1;
                    if (state == RDATA_ACK) nack <= sda_s;
                end
                // all SDA changes happen in the low phase, right after SCL falls
                if (scl_fall) begin
                    case (state)
                        ADDR: if (cnt == 4'd8) begin
                            if (sr[7:1] == SLAVE_ADDR) begin
                                state   <= ADDR_ACK;
                                sda_oen <= 1'b0;
                                busy_o  <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                        ADDR_ACK: if (sr[0]) begin
                            // ACK stays low until the first read bit replaces it
                            state      <= RDATA;
                            reg_re_o   <= 1'b1;
                            reg_addr_o <= {page, offset};
                            ld         <= 1'b1;
                        end else begin
                            state   <= OFFS;
                            sda_oen <= 1'b1;
                            cnt     <= 4'd0;
                        end
                        OFFS: if (cnt == 4'd8) begin
                            offset  <= sr;
                            sda_oen <= 1'b0;
                            state   <= OFFS_ACK;
                        end
                        OFFS_ACK, WDATA_ACK: begin
                            state   <= WDATA;
                            sda_oen <= 1'b1;
                            cnt     <= 4'd0;
                        end
                        WDATA: if (cnt == 4'd8) begin
                            reg_we_o    <= 1'b1;
                            reg_addr_o  <= {page, offset};
                            reg_wdata_o <= sr;
                            if (offset == 8'h01) page <= sr;
                            offset  <= offset + 8'd1;
                            sda_oen <= 1'b0;
                            state   <= WDATA_ACK;
                        end
                        RDATA: if (cnt == 4'd8) begin
                            state   <= RDATA_ACK;
                            sda_oen <= 1'b1;
                            offset  <= offset + 8'd1;
                        end else begin
                            sr      <= {sr[6:0], 1'b0};
                            sda_oen <= sr[6];
                        end
                        RDATA_ACK: if (nack) begin
                            state <= IDLE;
                        end else begin
                            state      <= RDATA;
                            reg_re_o   <= 1'b1;
                            reg_addr_o <= {page, offset};
                            ld         <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_si5340_i2c_target.sv
// tb_si5340_i2c_target: randomized I2C master driving si5340_i2c_target against a paged register model.
module tb_si5340_i2c_target;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_o, sda_oen, reg_we, reg_re, busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;

    int vectors = 0;
    int errs = 0;

    logic [7:0]  env_mem[int];
    logic [7:0]  ref_mem[int];
    logic [23:0] we_q[$], exp_we[$];
    logic [15:0] re_q[$], exp_re[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  m_page = 8'h00;
    logic [7:0]  m_off = 8'h00;
    bit          oen_low = 0;
    bit          prev_we = 0, prev_re = 0;

    assign sda_line = sda_m & (sda_oen | sda_o);

    always #5 clk = ~clk;

    si5340_i2c_target dut (
        .clk_i(clk), .arstn_i(arstn), .scl_i(scl), .sda_i(sda_line),
        .sda_o(sda_o), .sda_oen(sda_oen), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
        .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_rdata_i(reg_rdata), .busy_o(busy)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    // register-file environment: records strobes and answers reads one clk later
    always @(negedge clk) begin
        if (arstn) begin
            if (!sda_oen) oen_low = 1;
            if (reg_we || reg_re) begin
                vectors++;
                if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re)) begin
                    errs++;
                    $display("FAIL strobe_shape: we=%b re=%b prev_we=%b prev_re=%b, required single exclusive one-clk pulses",
                             reg_we, reg_re, prev_we, prev_re);
                end
            end
            if (reg_we) begin
                we_q.push_back({reg_addr, reg_wdata});
                env_mem[int'(reg_addr)] = reg_wdata;
            end
            if (reg_re) begin
                re_q.push_back(reg_addr);
                reg_rdata = env_mem.exists(int'(reg_addr)) ? env_mem[int'(reg_addr)] : init_val(reg_addr);
            end
            prev_we = reg_we;
            prev_re = reg_re;
        end else begin
            prev_we = 0;
            prev_re = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic q();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        q(); sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        q(); sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    task automatic bit_x(input logic b, output logic r);
        q(); sda_m = b; q(); scl = 1'b1; q(); r = sda_line; q(); scl = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
        bit_x(~ack, r);
    endtask

    task automatic i2c_write(input logic [7:0] off, input logic [7:0] d[$], output int nacks);
        logic a;
        nacks = 0;
        i2c_start();
        wbyte(8'hE8, a); nacks += int'(!a);
        wbyte(off, a);   nacks += int'(!a);
        foreach (d[i]) begin wbyte(d[i], a); nacks += int'(!a); end
        i2c_stop();
    endtask

    task automatic i2c_read(input logic [7:0] off, input int n, output logic [7:0] got[$], output int nacks);
        logic a;
        logic [7:0] b;
        nacks = 0;
        got = {};
        i2c_start();
        wbyte(8'hE8, a); nacks += int'(!a);
        wbyte(off, a);   nacks += int'(!a);
        i2c_start();
        wbyte(8'hE9, a); nacks += int'(!a);
        for (int i = 0; i < n; i++) begin rbyte(i != n - 1, b); got.push_back(b); end
        i2c_stop();
    endtask

    // reference: paged register space, offset auto-increments modulo 256, offset 0x01 is the page
    task automatic model_write(input logic [7:0] off, input logic [7:0] d[$]);
        m_off = off;
        foreach (d[i]) begin
            exp_we.push_back({m_page, m_off, d[i]});
            ref_mem[int'({m_page, m_off})] = d[i];
            if (m_off == 8'h01) m_page = d[i];
            m_off = m_off + 8'd1;
        end
    endtask

    task automatic model_read(input logic [7:0] off, input int n);
        m_off = off;
        for (int i = 0; i < n; i++) begin
            exp_re.push_back({m_page, m_off});
            exp_rd.push_back(ref_rd({m_page, m_off}));
            m_off = m_off + 8'd1;
        end
    endtask

    task automatic clear_q();
        we_q = {}; exp_we = {}; re_q = {}; exp_re = {}; exp_rd = {};
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (sda_oen !== 1'b1) begin errs++; $display("FAIL reset_oen: got %b want 1", sda_oen); end
        vectors++; if (sda_o !== 1'b0) begin errs++; $display("FAIL reset_sda_o: got %b want 0", sda_o); end
        vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if ({reg_we, reg_re} !== 2'b00) begin errs++; $display("FAIL reset_strobes: got %b want 00", {reg_we, reg_re}); end
        vectors++; if (reg_addr !== 16'h0000) begin errs++; $display("FAIL reset_addr: got %h want 0000", reg_addr); end
        vectors++; if (reg_wdata !== 8'h00) begin errs++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if ({sda_oen, busy} !== 2'b10) begin errs++; $display("FAIL post_reset_idle: oen,busy got %b want 10", {sda_oen, busy}); end
        m_page = 8'h00; m_off = 8'h00;
    endtask

    task automatic test_read();
        logic [7:0] got[$];
        int nk;
        clear_q();
        env_mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        env_mem[16'h0011] = 8'h3C; ref_mem[16'h0011] = 8'h3C;
        model_read(8'h10, 2);
        i2c_read(8'h10, 2, got, nk);
        vectors++; if (nk !== 0) begin errs++; $display("FAIL read_acks: got %0d nacks want 0", nk); end
        vectors++; if (re_q.size() !== 2 || got.size() !== 2) begin errs++; $display("FAIL read_count: re %0d bytes %0d want 2 2", re_q.size(), got.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                vectors++; if (re_q[i] !== exp_re[i]) begin errs++; $display("FAIL read_addr[%0d]: got %h want %h", i, re_q[i], exp_re[i]); end
                vectors++; if (got[i] !== exp_rd[i]) begin errs++; $display("FAIL read_data[%0d]: got %h want %h", i, got[i], exp_rd[i]); end
            end
        end
        vectors++; if (we_q.size() !== 0) begin errs++; $display("FAIL read_no_write: got %0d writes want 0", we_q.size()); end
        vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL read_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_write_page();
        int nk1, nk2;
        clear_q();
        model_write(8'h01, '{8'h02});
        model_write(8'h3A, '{8'h5C});
        i2c_write(8'h01, '{8'h02}, nk1);
        i2c_write(8'h3A, '{8'h5C}, nk2);
        vectors++; if (nk1 + nk2 !== 0) begin errs++; $display("FAIL wpage_acks: got %0d nacks want 0", nk1 + nk2); end
        vectors++; if (we_q.size() !== 2) begin errs++; $display("FAIL wpage_count: got %0d want 2", we_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                vectors++; if (we_q[i] !== exp_we[i]) begin errs++; $display("FAIL wpage_we[%0d]: got %h want %h", i, we_q[i], exp_we[i]); end
            end
        end
    endtask

    task automatic test_wrong_addr();
        logic a;
        clear_q();
        oen_low = 0;
        i2c_start();
        wbyte(8'hEA, a);
        vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL wrong_busy: got %b want 0", busy); end
        i2c_stop();
        vectors++; if (a !== 1'b0) begin errs++; $display("FAIL wrong_ack: got ack=%b want 0", a); end
        vectors++; if (oen_low !== 1'b0) begin errs++; $display("FAIL wrong_oen: sda pulled=%b want 0", oen_low); end
        vectors++; if (we_q.size() + re_q.size() !== 0) begin errs++; $display("FAIL wrong_strobes: got %0d want 0", we_q.size() + re_q.size()); end
    endtask

    task automatic test_burst_wrap();
        int nk;
        logic [7:0] pg;
        clear_q();
        pg = m_page;
        model_write(8'hFE, '{8'h11, 8'h22, 8'h33});
        i2c_write(8'hFE, '{8'h11, 8'h22, 8'h33}, nk);
        vectors++; if (nk !== 0) begin errs++; $display("FAIL wrap_acks: got %0d nacks want 0", nk); end
        vectors++; if (we_q.size() !== 3) begin errs++; $display("FAIL wrap_count: got %0d want 3", we_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (we_q[i] !== exp_we[i]) begin errs++; $display("FAIL wrap_we[%0d]: got %h want %h", i, we_q[i], exp_we[i]); end
            end
            vectors++; if (we_q[2][23:8] !== {pg, 8'h00}) begin errs++; $display("FAIL wrap_addr: got %h want %h", we_q[2][23:8], {pg, 8'h00}); end
        end
    endtask

    task automatic test_stop_mid();
        logic a, r;
        clear_q();
        i2c_start();
        wbyte(8'hE8, a);
        vectors++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b want 1", busy); end
        wbyte(8'h05, a);
        m_off = 8'h05;
        for (int i = 0; i < 4; i++) bit_x(i[0], r);
        i2c_stop();
        q();
        vectors++; if (we_q.size() !== 0) begin errs++; $display("FAIL mid_no_write: got %0d want 0", we_q.size()); end
        vectors++; if (sda_oen !== 1'b1) begin errs++; $display("FAIL mid_release: got %b want 1", sda_oen); end
        vectors++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_random();
        logic [7:0] d[$], got[$];
        logic [7:0] off;
        int n, nk1, nk2;
        for (int it = 0; it < 6; it++) begin
            clear_q();
            d = {};
            off = 8'($urandom);
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            model_write(off, d);
            i2c_write(off, d, nk1);
            model_read(off, n);
            i2c_read(off, n, got, nk2);
            vectors++; if (nk1 + nk2 !== 0) begin errs++; $display("FAIL rnd_acks[%0d]: got %0d nacks want 0", it, nk1 + nk2); end
            vectors++; if (we_q.size() !== n || re_q.size() !== n || got.size() !== n) begin
                errs++; $display("FAIL rnd_count[%0d]: we %0d re %0d rd %0d want %0d", it, we_q.size(), re_q.size(), got.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    vectors++; if (we_q[i] !== exp_we[i]) begin errs++; $display("FAIL rnd_we[%0d.%0d]: got %h want %h", it, i, we_q[i], exp_we[i]); end
                    vectors++; if (re_q[i] !== exp_re[i]) begin errs++; $display("FAIL rnd_re[%0d.%0d]: got %h want %h", it, i, re_q[i], exp_re[i]); end
                    vectors++; if (got[i] !== exp_rd[i]) begin errs++; $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", it, i, got[i], exp_rd[i]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic a;
        int nk;
        clear_q();
        model_write(8'h01, '{8'h07});
        i2c_write(8'h01, '{8'h07}, nk);
        env_mem[16'h0740] = 8'h00; ref_mem[16'h0740] = 8'h00;
        i2c_start();
        wbyte(8'hE8, a);
        wbyte(8'h40, a);
        i2c_start();
        wbyte(8'hE9, a);
        q(); q(); scl = 1'b1; q();
        vectors++; if (sda_oen !== 1'b0) begin errs++; $display("FAIL rstmid_driving: got oen=%b want 0", sda_oen); end
        arstn = 1'b0;
        #1;
        vectors++; if (sda_oen !== 1'b1) begin errs++; $display("FAIL rstmid_release: got oen=%b want 1", sda_oen); end
        m_page = 8'h00; m_off = 8'h00;
        repeat (4) @(negedge clk);
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        clear_q();
        model_write(8'h20, '{8'h9C});
        i2c_write(8'h20, '{8'h9C}, nk);
        vectors++; if (nk !== 0) begin errs++; $display("FAIL rstmid_acks: got %0d nacks want 0", nk); end
        vectors++; if (we_q.size() !== 1) begin errs++; $display("FAIL rstmid_count: got %0d want 1", we_q.size()); end
        else begin
            vectors++; if (we_q[0] !== exp_we[0]) begin errs++; $display("FAIL rstmid_we: got %h want %h", we_q[0], exp_we[0]); end
            vectors++; if (we_q[0][23:8] !== 16'h0020) begin errs++; $display("FAIL rstmid_page: got %h want 0020", we_q[0][23:8]); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_page();
        test_wrong_addr();
        test_burst_wrap();
        test_stop_mid();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
